// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Two-port arbiter for the shared program/data memory. Port 0 is the CPU
// control path (fetch + load/store). Port 1 is the loader/debug port. One
// transaction at a time is sequenced IDLE -> ISSUE -> (WAIT) -> DONE through
// a registered memory interface with a read latency of RD_LAT cycles.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds
// it until doneN pulses for one cycle. gntN is high from ISSUE through DONE.
// The request fields are captured on the grant edge, so later changes are
// ignored. Dropping req mid-transaction does not cancel it. A req still high
// in IDLE after done starts the next transaction.
//
// Parameters: AW address width, DW data width, RD_LAT read latency (1..3).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req/we/addr/wdata 0,1 request side of each port
//   gnt0/1, done0/1       ownership and one-cycle completion pulse
//   rdata                 read data, valid while done of a read is high
//   mem_en/we/addr/wdata  registered memory strobe and command
//   mem_rdata             memory read data (RD_LAT cycles after mem_en)
//   dbg_state             current FSM state (IDLE=0 ISSUE=1 WAIT=2 DONE=3)
//   lock0/1               bus lock, present only when ARB_LOCK_EN is defined
//
// Optional feature macro: ARB_LOCK_EN (bus locking across transactions).
module mem_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    dbg_state
`ifdef ARB_LOCK_EN
  ,
  input  logic          lock0,
  input  logic          lock1
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t        state_q, state_d;
  logic          owner_q;   // port currently (or last) owning the memory
  logic          last_q;    // last-grant pointer for round-robin
  logic          we_q;      // latched direction of the current transaction
  logic [1:0]    cnt_q;     // read latency countdown

  logic          rr_valid, rr_sel;
  logic          grant, grant_sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef ARB_LOCK_EN
  logic          locked_q;      // owner keeps the bus between transactions
  logic          owner_req;
  logic          owner_lock;
  logic          release_idle;  // locked owner gave up while idle

  assign owner_req  = owner_q ? req1  : req0;
  assign owner_lock = owner_q ? lock1 : lock0;
`endif

  // Round-robin pick: on contention the port not granted last wins.
  assign rr_valid = req0 | req1;
  assign rr_sel   = (req0 && req1) ? ~last_q : req1;

  assign sel_we    = grant_sel ? we1    : we0;
  assign sel_addr  = grant_sel ? addr1  : addr0;
  assign sel_wdata = grant_sel ? wdata1 : wdata0;

  // gnt/done decode the registered state and owner.
  assign gnt0      = (state_q != IDLE) && !owner_q;
  assign gnt1      = (state_q != IDLE) &&  owner_q;
  assign done0     = (state_q == DONE) && !owner_q;
  assign done1     = (state_q == DONE) &&  owner_q;
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and grant decision.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_sel = 1'b0;
`ifdef ARB_LOCK_EN
    release_idle = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_LOCK_EN
        if (locked_q) begin
          // Only the lock holder may start; the other port is blocked.
          if (owner_req) begin
            grant     = 1'b1;
            grant_sel = owner_q;
          end else if (!owner_lock) begin
            release_idle = 1'b1;
          end
        end else begin
          grant     = rr_valid;
          grant_sel = rr_sel;
        end
`else
        grant     = rr_valid;
        grant_sel = rr_sel;
`endif
        if (grant) state_d = ISSUE;
      end
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT:    if (cnt_q == 2'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latched request, registered memory command, read capture,
  // round-robin pointer and lock ownership.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      cnt_q     <= 2'd0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_LOCK_EN
      locked_q  <= 1'b0;
`endif
    end else begin
      // Strobe is high only in the ISSUE cycle that follows a grant.
      mem_en <= grant;
      mem_we <= grant & sel_we;

      if (grant) begin
        owner_q   <= grant_sel;
        we_q      <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end

      if (state_q == ISSUE) begin
        cnt_q <= LAT;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 2'd1;
      end

      if ((state_q == WAIT) && (cnt_q == 2'd1)) begin
        rdata <= mem_rdata;
      end

`ifdef ARB_LOCK_EN
      if (state_q == DONE) begin
        if (owner_lock) begin
          locked_q <= 1'b1;
        end else begin
          locked_q <= 1'b0;
          last_q   <= owner_q;
        end
      end else if (release_idle) begin
        locked_q <= 1'b0;
        last_q   <= owner_q;
      end
`else
      if (state_q == DONE) begin
        last_q <= owner_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// --------------
// Directed bench for mem_arbiter. Two instances: u_dut with RD_LAT=1 for the
// main scenarios and u_dut3 with RD_LAT=3 for the long-latency read. Each
// instance has a behavioural memory with a bench preload port.
// Optional feature macro: ARB_LOCK_EN (adds the locked-transfer scenario).
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (RD_LAT=1) signals ----------------
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;
`ifdef ARB_LOCK_EN
  logic          lock0, lock1;
`endif

  // ---------------- DUT (RD_LAT=3) signals ----------------
  logic          r3_req0, r3_we0;
  logic [AW-1:0] r3_addr0;
  logic          r3_gnt0, r3_gnt1, r3_done0, r3_done1;
  logic [DW-1:0] r3_rdata;
  logic          r3_mem_en, r3_mem_we;
  logic [AW-1:0] r3_mem_addr;
  logic [DW-1:0] r3_mem_wdata, r3_mem_rdata;
  logic [1:0]    r3_state;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
`ifdef ARB_LOCK_EN
    , .lock0(lock0), .lock1(lock1)
`endif
  );

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(r3_req0), .req1(1'b0), .we0(r3_we0), .we1(1'b0),
    .addr0(r3_addr0), .addr1('0), .wdata0('0), .wdata1('0),
    .gnt0(r3_gnt0), .gnt1(r3_gnt1), .done0(r3_done0), .done1(r3_done1),
    .rdata(r3_rdata), .mem_en(r3_mem_en), .mem_we(r3_mem_we),
    .mem_addr(r3_mem_addr), .mem_wdata(r3_mem_wdata), .mem_rdata(r3_mem_rdata),
    .dbg_state(r3_state)
`ifdef ARB_LOCK_EN
    , .lock0(1'b0), .lock1(1'b0)
`endif
  );

  // ---------------- memory models ----------------
  logic          bk_we;
  logic [AW-1:0] bk_addr;
  logic [DW-1:0] bk_data;
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] p0, p1, p2;

  // Read data is zero except on the exact cycle(s) the latency implies.
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr] : '0;
  end

  always @(posedge clk) begin
    if (bk_we) mem3[bk_addr] <= bk_data;
    else if (r3_mem_en && r3_mem_we) mem3[r3_mem_addr] <= r3_mem_wdata;
    p0 <= (r3_mem_en && !r3_mem_we) ? mem3[r3_mem_addr] : '0;
    p1 <= p0;
    p2 <= p1;
  end
  assign r3_mem_rdata = p2;

  // ---------------- monitors ----------------
  int en_cnt   = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (gnt0 && gnt1) both_cnt++;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE; lat_exp counts cycles after the grant
  // edge until done. rd_exp is the rdata value expected at done.
  task automatic run_txn(input bit port, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int lat_exp,
                         input logic [DW-1:0] rd_exp, input string tag);
    int n;
    int en0;
    en0 = en_cnt;
    if (port) begin req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = d; end
    else      begin req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = d; end
    tick();
    check({tag, "_gnt"}, 32'(port ? gnt1 : gnt0), 1);
    n = 1;
    while (!(port ? done1 : done0) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat_exp);
    check({tag, "_rdata"}, 32'(rdata), 32'(rd_exp));
    if (port) req1 = 1'b0; else req0 = 1'b0;
    tick();
    check({tag, "_mem_en"}, en_cnt - en0, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, cyc, nd, last_cyc, en0;
    logic [0:0] exp_owner;
`ifdef ARB_LOCK_EN
    int d1, d4, g0_cyc, g0_d1;
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    r3_req0 = 1'b0; r3_we0 = 1'b0; r3_addr0 = '0;
    bk_we = 1'b0; bk_addr = '0; bk_data = '0;

    // Preload both memories while in reset.
    tick();
    bk_we = 1'b1; bk_addr = 12'h010; bk_data = 16'h1234;
    tick();
    bk_addr = 12'h045; bk_data = 16'h5A5A;
    tick();
    bk_we = 1'b0;
    tick();

    // Reset state.
    check("rst_gnt",   {gnt1, gnt0}, 0);
    check("rst_done",  {done1, done0}, 0);
    check("rst_mem",   {mem_en, mem_we}, 0);
    check("rst_addr",  32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;

    // Reset in the middle of a read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
    tick();
    check("mr_issue", 32'({dbg_state, mem_en}), 32'({2'd1, 1'b1}));
    tick();
    check("mr_wait", 32'(dbg_state), 2);
    rst_n = 1'b0;
    tick();
    check("mr_state", 32'(dbg_state), 0);
    check("mr_outs",  {gnt0, gnt1, done0, done1, mem_en, mem_we}, 0);
    check("mr_addr",  32'(mem_addr), 0);
    check("mr_rdata", 32'(rdata), 0);
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 12'h010, 16'h0000, 3, 16'h1234, "mr_rd");

    // Write then read back; rdata holds the previous read across the write.
    run_txn(1'b0, 1'b1, 12'h123, 16'hBEEF, 2, 16'h1234, "wr123");
    check("wr123_mem", 32'(mem[12'h123]), 32'h0000BEEF);
    run_txn(1'b0, 1'b0, 12'h123, 16'h0000, 3, 16'hBEEF, "rd123");

    // Owner drops req during ISSUE; new field values must be ignored.
    en0 = en_cnt;
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h7FF; wdata1 = 16'h00AA;
    tick();
    check("drop_gnt", 32'(gnt1), 1);
    req1 = 1'b0; addr1 = 12'h001; wdata1 = 16'hFFFF;
    tick();
    check("drop_done", 32'(done1), 1);
    check("drop_addr", 32'(mem_addr), 32'h7FF);
    tick(); tick(); tick();
    check("drop_mem",   32'(mem[12'h7FF]), 32'h00AA);
    check("drop_en",    en_cnt - en0, 1);
    check("drop_state", 32'(dbg_state), 0);

    // Contention right after reset: order 0,1,0,1, one write every 3 cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h200; wdata0 = 16'h0A0A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h300; wdata1 = 16'h1B1B;
    tick();
    cyc = 1; nd = 0; last_cyc = 0;
    while (nd < 4 && cyc < 40) begin
      if (done0 || done1) begin
        exp_owner = exp_q.pop_front();
        check("rr_order", 32'(done1), 32'(exp_owner));
        nd++;
        last_cyc = cyc;
      end
      if (nd < 4) begin
        tick();
        cyc++;
      end
    end
    check("rr_count", nd, 4);
    check("rr_last_done", last_cyc, 11);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    check("rr_mem0", 32'(mem[12'h200]), 32'h0A0A);
    check("rr_mem1", 32'(mem[12'h300]), 32'h1B1B);

    // RD_LAT=3 read: done 5 cycles after the grant edge.
    r3_req0 = 1'b1; r3_we0 = 1'b0; r3_addr0 = 12'h045;
    tick();
    check("l3_gnt", 32'(r3_gnt0), 1);
    n = 1;
    while (!r3_done0 && n < 20) begin
      tick();
      n++;
    end
    check("l3_lat",   n, 5);
    check("l3_rdata", 32'(r3_rdata), 32'h5A5A);
    r3_req0 = 1'b0;
    tick(); tick();

`ifdef ARB_LOCK_EN
    // Three locked reads by port 1 with req0 held, then an unlocked one.
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h050; lock1 = 1'b1;
    tick();
    check("lk_gnt1", 32'(gnt1), 1);
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h060; wdata0 = 16'h0606;
    d1 = 0; d4 = -1; g0_cyc = -1; g0_d1 = -1; cyc = 1;
    while (!done0 && cyc < 80) begin
      if (done1) begin
        d1++;
        if (d1 == 4) begin
          req1 = 1'b0;
          d4 = cyc;
        end
      end else if (d1 == 3) begin
        lock1 = 1'b0;
      end
      if (gnt0 && g0_cyc < 0) begin
        g0_cyc = cyc;
        g0_d1 = d1;
      end
      tick();
      cyc++;
    end
    check("lk_done0", 32'(done0), 1);
    check("lk_d1_before_g0", g0_d1, 4);
    check("lk_g0_delay", g0_cyc - d4, 2);
    req0 = 1'b0;
    tick(); tick();
`endif

    check("both_gnt", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter for the single shared program/data memory. It shares the memory between the CPU control path (port 0: instruction fetch and load/store) and the memory loader/debug port (port 1). Requests follow a req/done handshake and are granted round-robin. One transaction at a time is sequenced through a registered memory interface with configurable read latency.

## Interface
- AW, 12, address width
- DW, 16, data width
- RD_LAT, 1, memory read latency in cycles (1..3): cycles from the mem_en cycle until mem_rdata is valid

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  transaction request, held until done
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  port owns memory; high from ISSUE through DONE
- done0 / done1  out  1  one-cycle completion pulse
- rdata  out  DW  read data, valid while done0/done1 of a read is high
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- lock0 / lock1  in  1  bus lock (only with ARB_LOCK_EN)

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - Sample req0/req1.
  - Single request: grant it.
  - Both requesting: grant the port not granted last. The last-grant pointer resets to 1, so port 0 wins first.
  - On grant, latch owner, we, addr and wdata, set gnt_owner, and go to ISSUE.
- ISSUE (exactly 1 cycle)
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched registers.
  - Write: go to DONE.
  - Read: load wait counter with RD_LAT and go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - On the edge where the counter reaches 1, capture mem_rdata into rdata and go to DONE.
- DONE (exactly 1 cycle)
  - done_owner = 1; rdata holds captured data (unchanged on writes).
  - Update the last-grant pointer to owner; go to IDLE; gnt drops.
- Latched fields are frozen during a transaction; input changes after the grant edge are ignored.
- If the owner drops req mid-transaction, the transaction still completes and done still pulses.
- A requester sees done, then must drop req or present its next request. req still high in IDLE starts a new transaction.
- mem_en/mem_we are 0 in IDLE, WAIT and DONE.
- Outputs are registered except gnt/done, which decode the registered state and owner.

## Timing
- Reset: state IDLE, pointer = 1, and gnt0/1, done0/1, mem_en, mem_we = 0. mem_addr, mem_wdata and rdata = 0.
- Reset mid-transaction: abort at the reset edge; mem_en low from the next cycle; no done pulse.
- Let edge E0 be the IDLE edge that grants.
  - gnt is high from the cycle after E0.
  - ISSUE is the cycle after E0.
  - Write: done in the cycle after E1 (2 cycles after the grant edge).
  - Read: done in the cycle after E(1+RD_LAT); for RD_LAT=1, 3 cycles after E0.
- Throughput: a continuously requesting single port gets a write every 3 cycles and a read every 3+RD_LAT cycles (IDLE is always visited).
- Simultaneous requests with both held: grants alternate 0,1,0,1.
- A request arriving during a transaction waits; it is evaluated in the next IDLE cycle.

## Configuration
- ARB_LOCK_EN defined:
  - If the owner's lock is high during DONE, ownership is kept. In the following IDLE cycles only that port's req is considered; the other port is blocked.
  - Ownership is released when a transaction completes with lock low, or when the owner is in IDLE with req and lock both low.
  - The pointer updates only on release.
- ARB_LOCK_EN undefined:
  - lock0/lock1 ports are absent.
  - Pure round-robin per transaction.

## Test plan
- Reset mid-read:
  - Stimulus: assert rst_n=0 in WAIT.
  - Response: next cycle all outputs 0, state IDLE, no done; subsequent req0 read of 0x010 completes normally.
- Single write then read, RD_LAT=1:
  - Stimulus: req0 writes 0xBEEF to 0x123, then reads 0x123.
  - Response: done0 two cycles after grant; read done0 three cycles after grant with rdata=0xBEEF; exactly one mem_en per transaction.
- Contention after reset:
  - Stimulus: req0 and req1 rise together and are held for four transactions.
  - Response: grant order 0,1,0,1; never both gnt high.
- Owner drops req mid-transaction:
  - Stimulus: req1 deasserts during ISSUE of a write of 0x00AA to 0x7FF.
  - Response: memory written; done1 still pulses; no further mem_en.
- RD_LAT=3 parameter run:
  - Stimulus: read of preloaded 0x5A5A.
  - Response: done exactly 5 cycles after the grant edge, rdata=0x5A5A.
- ARB_LOCK_EN:
  - Stimulus: port 1 issues three locked reads while req0 is held, then a read with lock1 low.
  - Response: port 0 is granted only after the unlocked transaction's DONE.
